// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit.
// Contents: the csr_op encoding, CSR address map, mstatus bit positions,
// trap cause codes, and a helper that flags read-only CSR addresses.
package csr_pkg;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_RW     = 3'd1,
        OP_RS     = 3'd2,
        OP_RC     = 3'd3,
        OP_ECALL  = 3'd4,
        OP_MRET   = 3'd5,
        OP_EBREAK = 3'd6
    } csr_op_e;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int CAUSE_ECALL_M    = 11;
    localparam int CAUSE_BREAKPOINT = 3;

    // Addresses with [11:10]=11 are read-only by the privileged address map.
    function automatic logic is_read_only(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit wrapping event counter with independently writable halves.
// Ports: clk, rst (sync, active high), inc (count enable), wr_lo/wr_hi
// (replace [31:0] / [63:32] from the matching half of wdata), value.
// Any write in a cycle takes precedence over the increment for that cycle.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [63:0] wdata,
    output logic [63:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= 64'd0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) value[31:0]  <= wdata[31:0];
            if (wr_hi) value[63:32] <= wdata[63:32];
        end else if (inc) begin
            value <= value + 64'd1;
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR unit: Zicsr read-modify-write, trap entry (ecall,
// ebreak, external exception) with MIE/MPIE stacking, and mret.
// Optional 64-bit mcycle/minstret counters when CSR_COUNTERS_EN is defined.
// Ports: clk, rst (sync, active high); csr_valid/csr_op/csr_addr/csr_wdata/
// csr_wsup describe the committing CSR instruction; pc is its PC;
// exc_valid/exc_cause/exc_tval report an external exception;
// instr_retire counts retirements. Outputs: csr_rdata (old value, comb),
// illegal, redirect_valid/redirect_pc (trap vector or mepc, comb).
module csr_file
    import csr_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          HART_ID     = 0,
    parameter logic [31:0] MTVEC_RESET = 32'h80000000,
    parameter logic [31:0] MISA_VAL    = 32'h40000100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid,
    input  logic [2:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            csr_wsup,
    input  logic [XLEN-1:0] pc,
    input  logic            exc_valid,
    input  logic [XLEN-1:0] exc_cause,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            instr_retire,
    output logic [XLEN-1:0] csr_rdata,
    output logic            illegal,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    logic            mie, mpie;
    logic [XLEN-1:0] mtvec, mepc, mcause, mtval, mscratch;

    logic            csr_act, trap_exc, trap_sw, do_mret, rw_op, wr_try, commit;
    logic            hit;
    logic [XLEN-1:0] rd_val, new_val;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle, minstret, cnt_wdata;
    logic        cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;
`endif

    // exc_valid outranks everything, so it gates every csr_valid action.
    always_comb begin
        trap_exc = exc_valid;
        csr_act  = csr_valid && !exc_valid;
        trap_sw  = csr_act && (csr_op == OP_ECALL || csr_op == OP_EBREAK);
        do_mret  = csr_act && (csr_op == OP_MRET);
        rw_op    = csr_act && (csr_op == OP_RW || csr_op == OP_RS || csr_op == OP_RC);
        wr_try   = (csr_op == OP_RW) || !csr_wsup;
    end

    // Read mux; hit marks an implemented address.
    always_comb begin
        rd_val = '0;
        hit    = 1'b0;
        case (csr_addr)
            ADDR_MSTATUS: begin
                hit = 1'b1;
                rd_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                rd_val[MSTATUS_MPIE] = mpie;
                rd_val[MSTATUS_MIE]  = mie;
            end
            ADDR_MISA:      begin hit = 1'b1; rd_val = XLEN'(MISA_VAL); end
            ADDR_MTVEC:     begin hit = 1'b1; rd_val = {mtvec[XLEN-1:2], 2'b00}; end
            ADDR_MSCRATCH:  begin hit = 1'b1; rd_val = mscratch; end
            ADDR_MEPC:      begin hit = 1'b1; rd_val = {mepc[XLEN-1:2], 2'b00}; end
            ADDR_MCAUSE:    begin hit = 1'b1; rd_val = mcause; end
            ADDR_MTVAL:     begin hit = 1'b1; rd_val = mtval; end
            ADDR_MVENDORID: hit = 1'b1;
            ADDR_MARCHID:   hit = 1'b1;
            ADDR_MHARTID:   begin hit = 1'b1; rd_val = XLEN'(HART_ID); end
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE, ADDR_CYCLE:     begin hit = 1'b1; rd_val = XLEN'(mcycle); end
            ADDR_MINSTRET, ADDR_INSTRET: begin hit = 1'b1; rd_val = XLEN'(minstret); end
            ADDR_MCYCLEH, ADDR_CYCLEH: begin
                if (XLEN == 32) begin hit = 1'b1; rd_val = XLEN'(mcycle[63:32]); end
            end
            ADDR_MINSTRETH, ADDR_INSTRETH: begin
                if (XLEN == 32) begin hit = 1'b1; rd_val = XLEN'(minstret[63:32]); end
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        illegal = !rst && rw_op && (!hit || (is_read_only(csr_addr) && wr_try));
        commit  = rw_op && !illegal && wr_try;
        case (csr_op)
            OP_RS:   new_val = rd_val | csr_wdata;
            OP_RC:   new_val = rd_val & ~csr_wdata;
            default: new_val = csr_wdata;
        endcase
        csr_rdata      = (rw_op && !illegal) ? rd_val : '0;
        redirect_valid = !rst && (trap_exc || trap_sw || do_mret);
        if (trap_exc || trap_sw) redirect_pc = {mtvec[XLEN-1:2], 2'b00};
        else if (do_mret)        redirect_pc = {mepc[XLEN-1:2], 2'b00};
        else                     redirect_pc = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= XLEN'(MTVEC_RESET);
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
            mscratch <= '0;
        end else if (trap_exc || trap_sw) begin
            mepc <= {pc[XLEN-1:2], 2'b00};
            mpie <= mie;
            mie  <= 1'b0;
            if (trap_exc) begin
                mcause <= exc_cause;
                mtval  <= exc_tval;
            end else if (csr_op == OP_ECALL) begin
                mcause <= XLEN'(CAUSE_ECALL_M);
                mtval  <= '0;
            end else begin
                mcause <= XLEN'(CAUSE_BREAKPOINT);
                mtval  <= pc;
            end
        end else if (do_mret) begin
            mie  <= mpie;
            mpie <= 1'b1;
        end else if (commit) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mie  <= new_val[MSTATUS_MIE];
                    mpie <= new_val[MSTATUS_MPIE];
                end
                ADDR_MTVEC:    mtvec    <= {new_val[XLEN-1:2], 2'b00};
                ADDR_MSCRATCH: mscratch <= new_val;
                ADDR_MEPC:     mepc     <= {new_val[XLEN-1:2], 2'b00};
                ADDR_MCAUSE:   mcause   <= new_val;
                ADDR_MTVAL:    mtval    <= new_val;
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    // For XLEN=32 each half takes the same 32-bit value; for XLEN=64 the
    // low address writes the whole counter.
    always_comb begin
        cnt_wdata = (XLEN == 32) ? {2{new_val[31:0]}} : 64'(new_val);
        cyc_wr_lo = commit && (csr_addr == ADDR_MCYCLE);
        ins_wr_lo = commit && (csr_addr == ADDR_MINSTRET);
        cyc_wr_hi = commit && (csr_addr == ((XLEN == 32) ? ADDR_MCYCLEH : ADDR_MCYCLE));
        ins_wr_hi = commit && (csr_addr == ((XLEN == 32) ? ADDR_MINSTRETH : ADDR_MINSTRET));
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (cyc_wr_lo),
        .wr_hi (cyc_wr_hi),
        .wdata (cnt_wdata),
        .value (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instr_retire),
        .wr_lo (ins_wr_lo),
        .wr_hi (ins_wr_hi),
        .wdata (cnt_wdata),
        .value (minstret)
    );
`else
    logic unused_retire;
    assign unused_retire = instr_retire;
`endif

endmodule

// File: tb/tb_csr_file.sv
// Directed testbench for csr_file (XLEN=32, HART_ID=5). A reference model
// of the architectural CSR state is checked against the DUT every cycle,
// and literal expectations from hand calculation pin the model.
module tb_csr_file;

    localparam logic [2:0] NONE = 3'd0, RW = 3'd1, RS = 3'd2, RC = 3'd3,
                           ECALL = 3'd4, MRET = 3'd5, EBREAK = 3'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_valid = 1'b0;
    logic [2:0]  csr_op = 3'd0;
    logic [11:0] csr_addr = 12'd0;
    logic [31:0] csr_wdata = 32'd0;
    logic        csr_wsup = 1'b0;
    logic [31:0] pc = 32'd0;
    logic        exc_valid = 1'b0;
    logic [31:0] exc_cause = 32'd0;
    logic [31:0] exc_tval = 32'd0;
    logic        instr_retire = 1'b0;
    logic [31:0] csr_rdata;
    logic        illegal;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_total = 0;
    int n_pass  = 0;

    csr_file #(.XLEN(32), .HART_ID(5)) dut (
        .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_op(csr_op),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_wsup(csr_wsup),
        .pc(pc), .exc_valid(exc_valid), .exc_cause(exc_cause),
        .exc_tval(exc_tval), .instr_retire(instr_retire),
        .csr_rdata(csr_rdata), .illegal(illegal),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic        model_ok = 1'b0;
    logic        m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch;
    logic [63:0] m_cycle, m_instret;

    function automatic logic m_impl(input logic [11:0] a);
        case (a)
            12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
            12'hF11, 12'hF12, 12'hF14: return 1'b1;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hB02, 12'hB80, 12'hB82,
            12'hC00, 12'hC02, 12'hC80, 12'hC82: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h301: return 32'h40000100;
            12'h305: return m_mtvec & ~32'h3;
            12'h340: return m_mscratch;
            12'h341: return m_mepc & ~32'h3;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'hF14: return 32'd5;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: return m_cycle[31:0];
            12'hB80, 12'hC80: return m_cycle[63:32];
            12'hB02, 12'hC02: return m_instret[31:0];
            12'hB82, 12'hC82: return m_instret[63:32];
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_new(input logic [2:0] op, input logic [31:0] old,
                                          input logic [31:0] w);
        if (op == RS) return old | w;
        if (op == RC) return old & ~w;
        return w;
    endfunction

    logic t_trap, t_mret, t_rw, t_wr, t_ill, t_commit;
    assign t_trap   = exc_valid || (csr_valid && (csr_op == ECALL || csr_op == EBREAK));
    assign t_mret   = csr_valid && !exc_valid && csr_op == MRET;
    assign t_rw     = csr_valid && !exc_valid && (csr_op == RW || csr_op == RS || csr_op == RC);
    assign t_wr     = (csr_op == RW) || !csr_wsup;
    assign t_ill    = !rst && t_rw && (!m_impl(csr_addr) || (csr_addr[11:10] == 2'b11 && t_wr));
    assign t_commit = t_rw && !t_ill && t_wr;

    always @(posedge clk) begin
        if (rst) begin
            model_ok <= 1'b1;
            m_mie <= 1'b0; m_mpie <= 1'b0;
            m_mtvec <= 32'h80000000;
            m_mepc <= 0; m_mcause <= 0; m_mtval <= 0; m_mscratch <= 0;
        end else if (t_trap) begin
            m_mepc <= pc & ~32'h3;
            m_mpie <= m_mie;
            m_mie  <= 1'b0;
            m_mcause <= exc_valid ? exc_cause : (csr_op == ECALL ? 32'd11 : 32'd3);
            m_mtval  <= exc_valid ? exc_tval  : (csr_op == ECALL ? 32'd0  : pc);
        end else if (t_mret) begin
            m_mie  <= m_mpie;
            m_mpie <= 1'b1;
        end else if (t_commit) begin
            case (csr_addr)
                12'h300: begin
                    m_mie  <= m_new(csr_op, m_read(csr_addr), csr_wdata) >> 3;
                    m_mpie <= m_new(csr_op, m_read(csr_addr), csr_wdata) >> 7;
                end
                12'h305: m_mtvec    <= m_new(csr_op, m_read(csr_addr), csr_wdata);
                12'h340: m_mscratch <= m_new(csr_op, m_read(csr_addr), csr_wdata);
                12'h341: m_mepc     <= m_new(csr_op, m_read(csr_addr), csr_wdata);
                12'h342: m_mcause   <= m_new(csr_op, m_read(csr_addr), csr_wdata);
                12'h343: m_mtval    <= m_new(csr_op, m_read(csr_addr), csr_wdata);
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    always @(posedge clk) begin
        if (rst) begin
            m_cycle   <= 64'd0;
            m_instret <= 64'd0;
        end else begin
            if (t_commit && csr_addr == 12'hB00)
                m_cycle <= {m_cycle[63:32], m_new(csr_op, m_read(csr_addr), csr_wdata)};
            else if (t_commit && csr_addr == 12'hB80)
                m_cycle <= {m_new(csr_op, m_read(csr_addr), csr_wdata), m_cycle[31:0]};
            else
                m_cycle <= m_cycle + 64'd1;
            if (t_commit && csr_addr == 12'hB02)
                m_instret <= {m_instret[63:32], m_new(csr_op, m_read(csr_addr), csr_wdata)};
            else if (t_commit && csr_addr == 12'hB82)
                m_instret <= {m_new(csr_op, m_read(csr_addr), csr_wdata), m_instret[31:0]};
            else
                m_instret <= m_instret + 64'(instr_retire);
        end
    end
`endif

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_rdata", csr_rdata, (t_rw && !t_ill) ? m_read(csr_addr) : 32'd0);
            chk("model_illegal", 32'(illegal), 32'(t_ill));
            chk("model_redirect_valid", 32'(redirect_valid), 32'(!rst && (t_trap || t_mret)));
            if (!rst && t_trap)
                chk("model_redirect_pc", redirect_pc, m_mtvec & ~32'h3);
            else if (!rst && t_mret)
                chk("model_redirect_pc", redirect_pc, m_mepc & ~32'h3);
        end
    end

    // ---------------- driver ----------------
    task automatic do_op(input logic [2:0] op, input logic [11:0] addr = 12'd0,
                         input logic [31:0] wdata = 32'd0, input logic wsup = 1'b0,
                         input logic [31:0] pc_v = 32'd0, input logic exc = 1'b0,
                         input logic [31:0] cause = 32'd0, input logic [31:0] tval = 32'd0,
                         input logic retire = 1'b0);
        @(posedge clk);
        #1;
        csr_valid = (op != NONE);
        csr_op = op; csr_addr = addr; csr_wdata = wdata; csr_wsup = wsup;
        pc = pc_v; exc_valid = exc; exc_cause = cause; exc_tval = tval;
        instr_retire = retire;
        @(negedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] addr);
        do_op(RS, addr, 32'd0, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset values
        rd(12'h300); chk("reset_mstatus", csr_rdata, 32'h1800); chk("reset_illegal", 32'(illegal), 0);
        rd(12'h305); chk("reset_mtvec", csr_rdata, 32'h80000000);
        rd(12'h301); chk("reset_misa", csr_rdata, 32'h40000100);

        // mtvec write, ecall
        do_op(RW, 12'h305, 32'h80001003); chk("rw_mtvec_old", csr_rdata, 32'h80000000);
        rd(12'h305); chk("mtvec_new", csr_rdata, 32'h80001000);
        do_op(ECALL, 12'h0, 32'h0, 1'b0, 32'h80000124);
        chk("ecall_redirect", 32'(redirect_valid), 1);
        chk("ecall_redirect_pc", redirect_pc, 32'h80001000);
        chk("ecall_rdata", csr_rdata, 0);
        rd(12'h341); chk("ecall_mepc", csr_rdata, 32'h80000124);
        rd(12'h342); chk("ecall_mcause", csr_rdata, 32'd11);
        rd(12'h343); chk("ecall_mtval", csr_rdata, 32'd0);

        // MIE stacking through ecall / mret
        do_op(RS, 12'h300, 32'h8); chk("rs_mstatus_old", csr_rdata, 32'h1800);
        do_op(ECALL, 12'h0, 32'h0, 1'b0, 32'h80000200);
        rd(12'h300); chk("trap_mstatus", csr_rdata, 32'h1880);
        do_op(MRET); chk("mret_redirect_pc", redirect_pc, 32'h80000200);
        rd(12'h300); chk("mret_mstatus", csr_rdata, 32'h1888);

        // suppressed writes and read-only addresses
        do_op(RW, 12'h340, 32'h12345678);
        do_op(RC, 12'h340, 32'hFF, 1'b1); chk("rc_wsup_rdata", csr_rdata, 32'h12345678);
        rd(12'h340); chk("rc_wsup_unchanged", csr_rdata, 32'h12345678);
        do_op(RW, 12'hF14, 32'h9); chk("rw_hartid_illegal", 32'(illegal), 1);
        chk("rw_hartid_rdata", csr_rdata, 0);
        rd(12'hF14); chk("rs_hartid_rdata", csr_rdata, 32'd5); chk("rs_hartid_legal", 32'(illegal), 0);
        rd(12'h7C0); chk("unimpl_illegal", 32'(illegal), 1);
`ifndef CSR_COUNTERS_EN
        rd(12'hB00); chk("mcycle_absent_illegal", 32'(illegal), 1);
`endif

        // external exception outranks a CSR write
        do_op(RW, 12'h340, 32'h0, 1'b0, 32'h80000400, 1'b1, 32'd2, 32'hDEAD);
        chk("exc_illegal", 32'(illegal), 0);
        chk("exc_redirect_pc", redirect_pc, 32'h80001000);
        rd(12'h340); chk("exc_mscratch", csr_rdata, 32'h12345678);
        rd(12'h342); chk("exc_mcause", csr_rdata, 32'd2);
        rd(12'h343); chk("exc_mtval", csr_rdata, 32'hDEAD);
        rd(12'h300); chk("exc_mstatus", csr_rdata, 32'h1880);

        // ebreak, exc alone, mepc alignment
        do_op(EBREAK, 12'h0, 32'h0, 1'b0, 32'h80000302);
        rd(12'h341); chk("ebreak_mepc", csr_rdata, 32'h80000300);
        rd(12'h342); chk("ebreak_mcause", csr_rdata, 32'd3);
        rd(12'h343); chk("ebreak_mtval", csr_rdata, 32'h80000302);
        do_op(NONE, 12'h0, 32'h0, 1'b0, 32'h80000500, 1'b1, 32'd7, 32'h55);
        chk("exc_alone_redirect", 32'(redirect_valid), 1);
        do_op(RW, 12'h341, 32'h80000007);
        rd(12'h341); chk("mepc_align", csr_rdata, 32'h80000004);
        do_op(MRET); chk("mret_new_mepc", redirect_pc, 32'h80000004);

`ifdef CSR_COUNTERS_EN
        do_op(RW, 12'hB00, 32'hFFFFFFFF);
        do_op(RW, 12'hB80, 32'h0);
        rd(12'hB00); chk("mcycle_lo_full", csr_rdata, 32'hFFFFFFFF);
        rd(12'hB80); chk("mcycle_hi_carry", csr_rdata, 32'd1);
        do_op(RW, 12'hC00, 32'h1); chk("cycle_alias_ro", 32'(illegal), 1);
        do_op(RW, 12'hB02, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        do_op(NONE, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        do_op(NONE, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        do_op(NONE, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        rd(12'hC02); chk("minstret_count", csr_rdata, 32'd2);
`endif

        // reset masks redirect and illegal
        @(posedge clk); #1;
        rst = 1'b1; csr_valid = 1'b1; csr_op = ECALL; exc_valid = 1'b0;
        @(negedge clk); #1;
        chk("rst_no_redirect", 32'(redirect_valid), 0);
        @(posedge clk); #1;
        csr_op = RW; csr_addr = 12'hF14; csr_wsup = 1'b0;
        @(negedge clk); #1;
        chk("rst_no_illegal", 32'(illegal), 0);
        @(posedge clk); #1;
        rst = 1'b0; csr_valid = 1'b0; csr_op = NONE;
        rd(12'h305); chk("rerst_mtvec", csr_rdata, 32'h80000000);
        rd(12'h300); chk("rerst_mstatus", csr_rdata, 32'h1800);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Parametrised machine-mode CSR unit for the single-issue NPC core.
- Handles the full Zicsr read-modify-write set, ecall/ebreak/external exception entry with mstatus MIE/MPIE stacking, and mret.
- Optionally provides 64-bit mcycle/minstret counters.
- Sits beside the GPR file at writeback: CSR state updates at the clock edge; read data and PC redirect are combinational in the same cycle.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- HART_ID, 0, value returned by mhartid.
- MTVEC_RESET, 32'h80000000, reset value of mtvec (zero-extended to XLEN).
- MISA_VAL, 32'h40000100, read-only misa value (RV32I); zero-extended when XLEN=64.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- csr_valid  in  1  committing instruction uses this unit this cycle
- csr_op  in  3  0 NONE, 1 RW, 2 RS, 3 RC, 4 ECALL, 5 MRET, 6 EBREAK
- csr_addr  in  12  CSR address
- csr_wdata  in  XLEN  rs1 value or zero-extended zimm, selected upstream
- csr_wsup  in  1  suppress the write for RS/RC (rs1=x0 or zimm=0)
- pc  in  XLEN  PC of the committing instruction
- exc_valid  in  1  external synchronous exception from another stage
- exc_cause  in  XLEN  mcause value for exc_valid
- exc_tval  in  XLEN  mtval value for exc_valid
- instr_retire  in  1  one instruction retires this cycle
- csr_rdata  out  XLEN  old CSR value, to rd
- illegal  out  1  access rejected
- redirect_valid  out  1  next PC comes from redirect_pc
- redirect_pc  out  XLEN  trap vector or mepc

Behaviour:
- Reset: mstatus=0x1800 (MPP=11, MIE=MPIE=0); mtvec=MTVEC_RESET; mepc, mcause, mtval, mscratch=0; counters=0.
- While rst=1, redirect_valid=0 and illegal=0.
- Supported CSRs:
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 11.
  - misa 0x301: read-only, value MISA_VAL.
  - mtvec 0x305: bits[1:0] read 0 (direct mode only).
  - mscratch 0x340.
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342.
  - mtval 0x343.
  - mvendorid 0xF11: reads 0.
  - marchid 0xF12: reads 0.
  - mhartid 0xF14: reads HART_ID.
- csr_rdata: combinational, pre-write value of csr_addr. Reads 0 for NONE/ECALL/MRET/EBREAK, and 0 when illegal.
- New value for RW/RS/RC:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - Committed at the posedge when csr_valid=1 and illegal=0.
  - RS/RC with csr_wsup=1 perform no write but still read.
  - RW always writes.
- illegal=1 when csr_valid=1 and op is RW/RS/RC and either:
  - the address is unimplemented, or
  - the address is read-only (addr[11:10]=11) and a write is performed (RW, or RS/RC with csr_wsup=0).
  - Effect: no state change, no redirect.
- Trap entry (ECALL, EBREAK, or exc_valid):
  - redirect_valid=1, redirect_pc={mtvec[XLEN-1:2],2'b00} in the same cycle.
  - At the edge: mepc<=pc & ~3; MPIE<=MIE; MIE<=0.
  - mcause<=11 for ECALL, 3 for EBREAK, exc_cause for exc_valid.
  - mtval<=0 for ECALL, pc for EBREAK, exc_tval for exc_valid.
- MRET: redirect_valid=1, redirect_pc=mepc; at the edge MIE<=MPIE, MPIE<=1.
- Priority: exc_valid > ECALL/EBREAK > MRET > RW/RS/RC. A lower-priority op in the same cycle has no effect and drives illegal=0.
- csr_valid=0: no CSR or trap action, except that exc_valid alone still traps.
- A CSR write to mtvec or mepc in cycle N is visible to a trap or mret in cycle N+1; not forwarded within cycle N.

Optional Feature:
- Macro CSR_COUNTERS_EN.
- Defined:
  - mcycle 0xB00 increments every cycle (rst=0).
  - minstret 0xB02 increments when instr_retire=1.
  - Both 64-bit, wrapping 2^64-1 -> 0.
  - XLEN=32: high halves at 0xB80/0xB82.
  - Read-only aliases 0xC00/0xC02 and, for XLEN=32, 0xC80/0xC82.
  - A CSR write to any half of a counter in a cycle replaces that half and suppresses that counter's increment that cycle.
  - XLEN=64: *h addresses are illegal.
- Undefined: no counter flops; all counter addresses are illegal.

Decomposition:
- Package csr_pkg:
  - csr_op encoding.
  - CSR address constants.
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11).
  - Cause constants CAUSE_ECALL_M=11, CAUSE_BREAKPOINT=3.
- Sub-module csr_counter64:
  - Inputs: inc, wr_lo, wr_hi, wdata.
  - Output: 64-bit value.
  - Instantiated twice, only under CSR_COUNTERS_EN.

Test Plan:
1. Reset, then read mstatus, mtvec, misa -> 0x1800, 0x80000000, 0x40000100; illegal=0.
2. RW mtvec=0x80001003 -> rdata 0x80000000; next-cycle read 0x80001000. ECALL at pc=0x80000124 -> redirect 0x80001000; then mepc=0x80000124, mcause=11.
3. Set MIE via RS 0x8; ECALL -> mstatus=0x1880. MRET -> redirect_pc=mepc, mstatus=0x1888.
4. RC mscratch with csr_wsup=1 -> value unchanged. RW to mhartid -> illegal=1, no change. RS to mhartid with csr_wsup=1 -> rdata=HART_ID, illegal=0.
5. exc_valid (cause 2, tval 0xDEAD) together with RW mscratch -> mscratch unchanged, mcause=2, mtval=0xDEAD, illegal=0.
6. CSR_COUNTERS_EN:
   - RW mcycle=0xFFFFFFFF, mcycleh=0 -> next read 0x00000000 / mcycleh=1 after one tick.
   - minstret counts only cycles with instr_retire=1.
